// File: rtl/iter_div.sv
// Iterative restoring divider: one quotient bit per clock, signed or unsigned,
// {remainder, quotient} result with divide-by-zero flag and cancel support.
module iter_div #(
  parameter int WIDTH      = 32,
  parameter int EARLY_ZERO = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  input  logic               cancel,
  output logic               busy,
  output logic               ready,
  output logic               stall,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  stateT            state, stateNext;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, divisor, opaHold;
  logic             negQuo, negRem, zeroHold;

  logic             zeroEarly, accept, stepEn, finish;
  logic [WIDTH-1:0] absA, absB;
  logic [WIDTH:0]   remShift, diff;
  logic [WIDTH-1:0] stepRem, stepQuo, quoFix, remFix;

  assign absA      = (signed_div && opa[WIDTH-1]) ? -opa : opa;
  assign absB      = (signed_div && opb[WIDTH-1]) ? -opb : opb;
  assign zeroEarly = (EARLY_ZERO != 0) && (opb == '0);

  // rem < divisor always holds, so diff[WIDTH] is exactly the borrow of the trial subtract
  assign remShift = {rem, quo[WIDTH-1]};
  assign diff     = remShift - {1'b0, divisor};
  assign stepRem  = diff[WIDTH] ? remShift[WIDTH-1:0] : diff[WIDTH-1:0];
  assign stepQuo  = {quo[WIDTH-2:0], ~diff[WIDTH]};
  assign quoFix   = negQuo ? -stepQuo : stepQuo;
  assign remFix   = negRem ? -stepRem : stepRem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    stepEn    = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !cancel) begin
          accept    = 1'b1;
          stateNext = zeroEarly ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cancel) begin
          stateNext = IDLE;
        end else begin
          stepEn = 1'b1;
          if (cnt == LAST_STEP) begin
            finish    = 1'b1;
            stateNext = DONE;
          end
        end
      end
      DONE: begin
        if (start && !cancel) begin
          accept    = 1'b1;
          stateNext = zeroEarly ? DONE : BUSY;
        end else begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign busy  = (state == BUSY);
  assign ready = (state == DONE);
  assign stall = ((state == IDLE) && start && !cancel) || (state == BUSY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      divisor     <= '0;
      opaHold     <= '0;
      negQuo      <= 1'b0;
      negRem      <= 1'b0;
      zeroHold    <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= absA;
      divisor  <= absB;
      opaHold  <= opa;
      negQuo   <= signed_div && (opa[WIDTH-1] ^ opb[WIDTH-1]);
      negRem   <= signed_div && opa[WIDTH-1];
      zeroHold <= (opb == '0);
      if (zeroEarly) begin
        result      <= {opa, {WIDTH{1'b1}}};
        div_by_zero <= 1'b1;
      end
    end else if (stepEn) begin
      rem <= stepRem;
      quo <= stepQuo;
      cnt <= cnt + 1'b1;
      // Final step writes the sign-corrected result straight from the step logic
      if (finish) begin
        result      <= zeroHold ? {opaHold, {WIDTH{1'b1}}} : {remFix, quoFix};
        div_by_zero <= zeroHold;
      end
    end
  end

endmodule

// File: tb/tb_iter_div.sv
// Directed bench for iter_div: 32-bit instances with and without early zero
// completion, plus an 8-bit instance for narrow-width corner cases.
module tb_iter_div;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetN, start, signedDiv, cancel;
  logic [31:0] opa, opb;
  logic        busy, ready, stall, divZero;
  logic [63:0] result;
  logic        busyNz, readyNz, stallNz, divZeroNz;
  logic [63:0] resultNz;
  logic        start8, signed8;
  logic [7:0]  opa8, opb8;
  logic        busy8, ready8, stall8, divZero8;
  logic [15:0] result8;

  int nTests = 0;
  int nFail  = 0;

  iter_div #(.WIDTH(32), .EARLY_ZERO(1)) dut (
    .clk(clk), .reset(resetN), .start(start), .signed_div(signedDiv), .opa(opa), .opb(opb),
    .cancel(cancel), .busy(busy), .ready(ready), .stall(stall), .result(result),
    .div_by_zero(divZero));

  iter_div #(.WIDTH(32), .EARLY_ZERO(0)) dutNz (
    .clk(clk), .reset(resetN), .start(start), .signed_div(signedDiv), .opa(opa), .opb(opb),
    .cancel(cancel), .busy(busyNz), .ready(readyNz), .stall(stallNz), .result(resultNz),
    .div_by_zero(divZeroNz));

  iter_div #(.WIDTH(8), .EARLY_ZERO(1)) dut8 (
    .clk(clk), .reset(resetN), .start(start8), .signed_div(signed8), .opa(opa8), .opb(opb8),
    .cancel(cancel), .busy(busy8), .ready(ready8), .stall(stall8), .result(result8),
    .div_by_zero(divZero8));

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts an operation; the accepting edge is edge 1. Operands are scrambled after it.
  task automatic doDiv(input logic [31:0] a, input logic [31:0] b, input logic sg,
                       output int lat, output int stallCyc);
    opa = a; opb = b; signedDiv = sg; start = 1'b1;
    lat = -1; stallCyc = 0;
    #1;
    if (stall) stallCyc++;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        start = 1'b0; opa = 32'hDEADBEEF; opb = 32'h3;
      end
      if (ready) begin
        lat = e;
        break;
      end
      if (stall) stallCyc++;
    end
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sg, input logic [63:0] expRes, input int expLat,
                       input logic expDz);
    int lat, stallCyc;
    doDiv(a, b, sg, lat, stallCyc);
    checkVal({tag, ".lat"}, 64'(lat), 64'(expLat));
    checkVal({tag, ".res"}, result, expRes);
    checkVal({tag, ".dz"}, 64'(divZero), 64'(expDz));
    checkVal({tag, ".stallCyc"}, 64'(stallCyc), 64'(expLat));
    checkVal({tag, ".stallDone"}, 64'(stall), 64'd0);
    checkVal({tag, ".busyDone"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic runOp8(input int idx, input logic [7:0] a, input logic [7:0] b,
                        input logic sg, input logic [15:0] expRes, input logic expDz);
    int lat;
    string tag;
    tag = $sformatf("w8[%0d]", idx);
    opa8 = a; opb8 = b; signed8 = sg; start8 = 1'b1; lat = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        start8 = 1'b0; opa8 = 8'h5A; opb8 = 8'h3;
      end
      if (ready8) begin
        lat = e;
        break;
      end
    end
    checkVal({tag, ".lat"}, 64'(lat), expDz ? 64'd1 : 64'd9);
    checkVal({tag, ".res"}, 64'(result8), 64'(expRes));
    checkVal({tag, ".dz"}, 64'(divZero8), 64'(expDz));
    checkVal({tag, ".idle"}, 64'({busy8, stall8}), 64'd0);
    @(posedge clk); #1;
  endtask

  logic [7:0]  a8v  [9] = '{8'd200, 8'd255, 8'h80, 8'h80, 8'd127, 8'hFF, 8'h80, 8'h9C, 8'd3};
  logic [7:0]  b8v  [9] = '{8'd7, 8'd16, 8'hFF, 8'd3, 8'hFB, 8'd7, 8'hFF, 8'd0, 8'd200};
  logic        s8v  [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [15:0] e8v  [9] = '{16'h041C, 16'h0F0F, 16'h0080, 16'hFED6, 16'h02E7, 16'hFF00,
                            16'h8000, 16'h9CFF, 16'h0300};

  initial begin
    int lat, latNz, stallCyc, readyCnt;
    resetN = 1'b0; start = 1'b0; cancel = 1'b0; signedDiv = 1'b0; opa = '0; opb = '0;
    start8 = 1'b0; signed8 = 1'b0; opa8 = '0; opb8 = '0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst.result", result, 64'd0);
    checkVal("rst.flags", 64'({busy, ready, stall, divZero}), 64'd0);
    resetN = 1'b1;
    @(posedge clk); #1;

    runOp("u100/7", 32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 33, 1'b0);
    checkVal("nz.u100/7", resultNz, {32'h2, 32'hE});
    runOp("s-7/2", 32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 1'b0);
    runOp("sMin/-1", 32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, 33, 1'b0);
    runOp("s7/-2", 32'd7, 32'hFFFFFFFE, 1'b1, {32'h1, 32'hFFFFFFFD}, 33, 1'b0);
    runOp("s-7/-2", 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, {32'hFFFFFFFF, 32'h3}, 33, 1'b0);
    runOp("uMax/1", 32'hFFFFFFFF, 32'd1, 1'b0, {32'h0, 32'hFFFFFFFF}, 33, 1'b0);
    runOp("uMin/Max", 32'h80000000, 32'hFFFFFFFF, 1'b0, {32'h80000000, 32'h0}, 33, 1'b0);
    runOp("u-7/2", 32'hFFFFFFF9, 32'd2, 1'b0, {32'h1, 32'h7FFFFFFC}, 33, 1'b0);

    // Divide by zero: early instance finishes at edge 1, iterating instance at edge 33
    runOp("u5/0", 32'd5, 32'd0, 1'b0, {32'h5, 32'hFFFFFFFF}, 1, 1'b1);
    latNz = -1;
    for (int e = 2; e <= 100; e++) begin
      if (e > 2) begin
        @(posedge clk); #1;
      end
      if (readyNz) begin
        latNz = e;
        break;
      end
    end
    checkVal("nz.u5/0.lat", 64'(latNz), 64'd33);
    checkVal("nz.u5/0.res", resultNz, {32'h5, 32'hFFFFFFFF});
    checkVal("nz.u5/0.dz", 64'(divZeroNz), 64'd1);
    checkVal("nz.u5/0.idle", 64'({busyNz, stallNz}), 64'd0);
    @(posedge clk); #1;

    // Cancel + start together in IDLE: start dropped
    opa = 32'd9; opb = 32'd3; start = 1'b1; cancel = 1'b1;
    #1 checkVal("cs.stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    checkVal("cs.state", 64'({busy, ready}), 64'd0);
    start = 1'b0; cancel = 1'b0;

    // Cancel in cycle 10 of BUSY, with a start pulse during BUSY that must be ignored
    opa = 32'd1000; opb = 32'd10; signedDiv = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 2; e <= 10; e++) begin
      @(posedge clk); #1;
      if (e == 5) begin
        start = 1'b1; opa = 32'd77; opb = 32'd0;
      end
      if (e == 6) start = 1'b0;
    end
    checkVal("cancel.busyBefore", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    checkVal("cancel.state", 64'({busy, ready}), 64'd0);
    checkVal("cancel.result", result, {32'h5, 32'hFFFFFFFF});
    checkVal("cancel.dz", 64'(divZero), 64'd1);
    runOp("postCancel", 32'd1000, 32'd10, 1'b0, {32'h0, 32'd100}, 33, 1'b0);

    // Back-to-back: start held through DONE
    opa = 32'd100; opb = 32'd7; signedDiv = 1'b0; start = 1'b1; lat = -1;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        opa = 32'd50; opb = 32'd5;
      end
      if (ready) begin
        lat = e;
        break;
      end
    end
    checkVal("b2b.lat1", 64'(lat), 64'd33);
    checkVal("b2b.res1", result, {32'h2, 32'hE});
    @(posedge clk); #1;
    start = 1'b0; opa = 32'hDEADBEEF; opb = 32'h3;
    checkVal("b2b.noGap", 64'(busy), 64'd1);
    lat = -1;
    for (int e = 2; e <= 100; e++) begin
      @(posedge clk); #1;
      if (ready) begin
        lat = e;
        break;
      end
    end
    checkVal("b2b.lat2", 64'(lat), 64'd33);
    checkVal("b2b.res2", result, {32'h0, 32'd10});
    @(posedge clk); #1;

    runOp("sMin/0", 32'h80000000, 32'd0, 1'b1, {32'h80000000, 32'hFFFFFFFF}, 1, 1'b1);

    // Asynchronous reset at cycle 5 of an operation
    opa = 32'd1000; opb = 32'd3; signedDiv = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 resetN = 1'b0;
    #1;
    checkVal("arst.result", result, 64'd0);
    checkVal("arst.flags", 64'({busy, ready, stall, divZero}), 64'd0);
    @(posedge clk); #1;
    resetN = 1'b1;
    readyCnt = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      if (ready) readyCnt++;
    end
    checkVal("arst.noReady", 64'(readyCnt), 64'd0);
    runOp("postReset", 32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 1'b0);

    for (int i = 0; i < 9; i++) begin
      runOp8(i, a8v[i], b8v[i], s8v[i], e8v[i], (b8v[i] == 8'd0));
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
